// File: rtl/knn_pkg.sv
// Shared definitions for the KNN scheduler slice: default widths, the
// empty-slot distance value and the sequencer state encoding.
package knn_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_IDX_W  = 10;
   localparam int DEF_DIST_W = 32;
   localparam int DEF_K      = 4;

   // Distance held by an unused neighbour slot.
   localparam logic [DEF_DIST_W-1:0] DIST_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_WAIT_MEM,
      S_ISSUE,
      S_WAIT_RES,
      S_INSERT,
      S_FIN
   } state_t;

endpackage

// File: rtl/knn_topk.sv
// Sorted K-slot nearest-neighbour list. Slot 0 is the nearest. A new entry
// goes to the first slot whose distance is strictly larger (or to the first
// empty slot), pushing the remaining slots up and dropping the last one.
module knn_topk
   import knn_pkg::*;
#(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int DIST_W = DEF_DIST_W,
   parameter int K      = DEF_K
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                ins,
   input  logic [DIST_W-1:0]   ins_d,
   input  logic [IDX_W-1:0]    ins_i,
   output logic [K*IDX_W-1:0]  nb_idx,
   output logic [K*DIST_W-1:0] nb_dist,
   output logic [3:0]          nb_cnt
);

   localparam logic [3:0] K_CNT = 4'(K);

   logic [DIST_W-1:0] dist_q [K];
   logic [IDX_W-1:0]  idx_q  [K];
   logic [3:0]        cnt_q;
   logic [DIST_W-1:0] dist_n [K];
   logic [IDX_W-1:0]  idx_n  [K];
   logic [3:0]        cnt_n;
   logic              found;

   // Parallel compare and shift: once the insertion slot is found, every
   // higher slot takes its lower neighbour's old contents.
   always_comb begin
      found     = (ins_d < dist_q[0]) || (cnt_q == 4'd0);
      dist_n[0] = found ? ins_d : dist_q[0];
      idx_n[0]  = found ? ins_i : idx_q[0];
      for (int unsigned s = 1; s < K; s++) begin
         dist_n[s] = dist_q[s];
         idx_n[s]  = idx_q[s];
         if (found) begin
            dist_n[s] = dist_q[s-1];
            idx_n[s]  = idx_q[s-1];
         end else if ((ins_d < dist_q[s]) || (cnt_q == 4'(s))) begin
            dist_n[s] = ins_d;
            idx_n[s]  = ins_i;
            found     = 1'b1;
         end
      end
      cnt_n = (found && (cnt_q < K_CNT)) ? cnt_q + 4'd1 : cnt_q;
   end

   // List storage: cleared on reset or at the start of a search.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < K; s++) begin
            dist_q[s] <= '1;
            idx_q[s]  <= '0;
         end
         cnt_q <= '0;
      end else if (clr) begin
         for (int unsigned s = 0; s < K; s++) begin
            dist_q[s] <= '1;
            idx_q[s]  <= '0;
         end
         cnt_q <= '0;
      end else if (ins) begin
         dist_q <= dist_n;
         idx_q  <= idx_n;
         cnt_q  <= cnt_n;
      end
   end

   // Flatten the slots onto the packed output buses.
   always_comb begin
      nb_idx  = '0;
      nb_dist = '0;
      for (int unsigned s = 0; s < K; s++) begin
         nb_idx[s*IDX_W +: IDX_W]   = idx_q[s];
         nb_dist[s*DIST_W +: DIST_W] = dist_q[s];
      end
   end

   assign nb_cnt = cnt_q;

endmodule

// File: rtl/knn_sched.sv
// KNN search sequencer: fetches each point from the point memory, hands the
// (test, data) pair to the shared distance unit and folds every result into
// the K-nearest list.
module knn_sched
   import knn_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int DIST_W = DEF_DIST_W,
   parameter int K      = DEF_K
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [IDX_W:0]      n_points,
   input  logic [DATA_W-1:0]   test_point,
   output logic                busy,
   output logic                done,
   output logic                mem_en,
   output logic [IDX_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                dist_valid,
   input  logic                dist_ready,
   output logic [DATA_W-1:0]   dist_a,
   output logic [DATA_W-1:0]   dist_b,
   input  logic                dist_res_valid,
   input  logic [DIST_W-1:0]   dist_res,
   output logic [K*IDX_W-1:0]  nb_idx,
   output logic [K*DIST_W-1:0] nb_dist,
   output logic [3:0]          nb_cnt
);

   localparam logic [IDX_W:0] IDX_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t            state;
   logic [IDX_W:0]    idx;
   logic [IDX_W:0]    n_lat;
   logic [DIST_W-1:0] res_d;

   // idx carries one extra bit so a full 2**IDX_W scan never wraps.
   assign mem_addr = idx[IDX_W-1:0];

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         n_lat      <= '0;
         res_d      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_en     <= 1'b0;
         dist_valid <= 1'b0;
         dist_a     <= '0;
         dist_b     <= '0;
      end else begin
         done   <= 1'b0;
         mem_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_lat  <= n_points;
                  dist_a <= test_point;
                  idx    <= '0;
                  busy   <= 1'b1;
                  state  <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (n_lat == '0) begin
                  state <= S_FIN;
               end else begin
                  mem_en <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: state <= S_WAIT_MEM;
            S_WAIT_MEM: begin
               dist_b     <= mem_rdata;
               dist_valid <= 1'b1;
               state      <= S_ISSUE;
            end
            S_ISSUE: begin
               if (dist_ready) begin
                  dist_valid <= 1'b0;
                  state      <= S_WAIT_RES;
               end
            end
            S_WAIT_RES: begin
               if (dist_res_valid) begin
                  res_d <= dist_res;
                  state <= S_INSERT;
               end
            end
            S_INSERT: begin
               if ((idx + IDX_ONE) == n_lat) begin
                  state <= S_FIN;
               end else begin
                  idx    <= idx + IDX_ONE;
                  mem_en <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   knn_topk #(
      .IDX_W  (IDX_W),
      .DIST_W (DIST_W),
      .K      (K)
   ) u_topk (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == S_CLEAR),
      .ins     (state == S_INSERT),
      .ins_d   (res_d),
      .ins_i   (idx[IDX_W-1:0]),
      .nb_idx  (nb_idx),
      .nb_dist (nb_dist),
      .nb_cnt  (nb_cnt)
   );

endmodule

// File: tb/tb_knn_sched.sv
// Bench for knn_sched: point memory and distance-unit models, a reference
// model that ranks points by (distance, index), and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_knn_sched;
   import knn_pkg::*;

   localparam int DATA_W = 32;
   localparam int IDX_W  = 10;
   localparam int DIST_W = 32;
   localparam int K      = 4;
   localparam int NMAX   = 1024;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [IDX_W:0]      n_points = '0;
   logic [DATA_W-1:0]   test_point = '0;
   logic                busy, done, mem_en, dist_valid;
   logic [IDX_W-1:0]    mem_addr;
   logic [DATA_W-1:0]   mem_rdata;
   logic                dist_ready;
   logic [DATA_W-1:0]   dist_a, dist_b;
   logic                dist_res_valid;
   logic [DIST_W-1:0]   dist_res;
   logic [K*IDX_W-1:0]  nb_idx;
   logic [K*DIST_W-1:0] nb_dist;
   logic [3:0]          nb_cnt;

   knn_sched #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .DIST_W (DIST_W),
      .K      (K)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .n_points       (n_points),
      .test_point     (test_point),
      .busy           (busy),
      .done           (done),
      .mem_en         (mem_en),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .dist_valid     (dist_valid),
      .dist_ready     (dist_ready),
      .dist_a         (dist_a),
      .dist_b         (dist_b),
      .dist_res_valid (dist_res_valid),
      .dist_res       (dist_res),
      .nb_idx         (nb_idx),
      .nb_dist        (nb_dist),
      .nb_cnt         (nb_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                  n;
      int                  lat;
      logic [K*DIST_W-1:0] d;
      logic [K*IDX_W-1:0]  i;
      logic [3:0]          cnt;
   } exp_t;

   exp_t              expq[$];
   exp_t              last_exp;
   logic [DATA_W-1:0] mem  [NMAX];
   logic [DIST_W-1:0] dtab [NMAX];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int fetch_cnt = 0;
   int acc_cnt = 0;
   logic addr_err = 1'b0;
   logic hold_err = 1'b0;
   logic [IDX_W-1:0]  last_addr = '0;
   logic [DATA_W-1:0] cur_tp = '0;
   bit du_en = 1'b1;
   bit inj_res = 1'b0;
   bit rnd_mode = 1'b0;
   bit spur = 1'b0;
   int stall_cfg = 0;
   int lat_cfg = 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: the K smallest distances, ties broken by lower index.
   function automatic exp_t model(input int n, input int lat);
      exp_t e;
      bit   used [NMAX];
      int   best;
      e.n   = n;
      e.lat = lat;
      e.cnt = 4'((n < K) ? n : K);
      e.d   = '0;
      e.i   = '0;
      for (int r = 0; r < K; r++) begin
         e.d[r*DIST_W +: DIST_W] = DIST_MAX;
         e.i[r*IDX_W +: IDX_W]   = '0;
         if (r < n) begin
            best = -1;
            for (int j = 0; j < n; j++)
               if (!used[j] && (best < 0 || dtab[j] < dtab[best])) best = j;
            used[best] = 1'b1;
            e.d[r*DIST_W +: DIST_W] = dtab[best];
            e.i[r*IDX_W +: IDX_W]   = IDX_W'(best);
         end
      end
      return e;
   endfunction

   task automatic fill_dtab();
      for (int j = 0; j < NMAX; j++)
         dtab[j] = ($urandom_range(0, 15) == 0) ? DIST_MAX : DIST_W'($urandom_range(0, 60));
   endtask

   task automatic chk_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_dist_valid", dist_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_dist_a", dist_a, 0);
      chk("rst_dist_b", dist_b, 0);
      chk("rst_nb_idx", nb_idx, 0);
      chk("rst_nb_dist", nb_dist, {K{DIST_MAX}});
      chk("rst_nb_cnt", nb_cnt, 0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One search: queue the expected result, pulse start, wait for the scoreboard.
   task automatic run(input int n, input bit poke);
      exp_t e;
      int   g;
      int   budget;
      e = model(n, (n == 0) ? 3 : -1);
      last_exp  = e;
      fetch_cnt = 0;
      acc_cnt   = 0;
      addr_err  = 1'b0;
      hold_err  = 1'b0;
      cur_tp    = $urandom;
      expq.push_back(e);
      @(negedge clk);
      start = 1'b1; n_points = (IDX_W+1)'(n); test_point = cur_tp; t0 = cyc;
      @(negedge clk);
      start = 1'b0; n_points = (IDX_W+1)'($urandom); test_point = $urandom;
      chk("busy_after_start", busy, 1'b1);
      if (poke) begin
         repeat (2) @(negedge clk);
         start = 1'b1; n_points = 11'd5; test_point = $urandom;
         @(negedge clk);
         start = 1'b0;
      end
      budget = 60 + n * 20;
      g = 0;
      while (expq.size() != 0 && g < budget) begin
         @(negedge clk);
         g++;
      end
      chk("completion", expq.size() == 0, 1'b1);
      if (expq.size() != 0) begin
         expq.delete();
         do_reset();
      end else begin
         repeat (3) @(negedge clk);
         chk("stable_dist", nb_dist, last_exp.d);
         chk("stable_idx", nb_idx, last_exp.i);
         chk("stable_cnt", nb_cnt, last_exp.cnt);
      end
   endtask

   initial forever @(posedge clk) cyc++;

   // Point memory: data valid only during the cycle after mem_en.
   initial begin
      logic             pend;
      logic [IDX_W-1:0] pa;
      pend = 1'b0;
      pa = '0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (pend) mem_rdata = mem[pa];
         else      mem_rdata = $urandom;
         pend = 1'b0;
         if (mem_en) begin
            pend = 1'b1;
            pa = mem_addr;
            if (int'(mem_addr) != (fetch_cnt % NMAX)) addr_err = 1'b1;
            last_addr = mem_addr;
            fetch_cnt++;
         end
      end
   end

   // Distance unit: stalls ready, checks the request is held, returns the
   // tabulated distance for the k-th accepted request after a set latency.
   initial begin
      int                du_st, sc, lc, st_len, l_len;
      logic [DATA_W-1:0] a0, b0;
      logic [DIST_W-1:0] rv;
      du_st = 0; sc = 0; lc = 0; st_len = 0; l_len = 1;
      a0 = '0; b0 = '0; rv = '0;
      dist_ready = 1'b0; dist_res_valid = 1'b0; dist_res = '0;
      forever begin
         @(negedge clk);
         dist_res_valid = 1'b0;
         dist_res = $urandom;
         if (rst || !du_en) begin
            du_st = 0;
            dist_ready = 1'b0;
            dist_res_valid = inj_res;
            if (inj_res) dist_res = '0;
         end else begin
            case (du_st)
               0: if (dist_valid) begin
                  a0 = dist_a; b0 = dist_b; sc = 0;
                  st_len = rnd_mode ? int'($urandom_range(0, 3)) : stall_cfg;
                  l_len  = rnd_mode ? int'($urandom_range(1, 4)) : lat_cfg;
                  if (st_len == 0) begin dist_ready = 1'b1; du_st = 2; end
                  else du_st = 1;
               end
               1: begin
                  if (!dist_valid || dist_a !== a0 || dist_b !== b0) hold_err = 1'b1;
                  sc++;
                  if (sc == st_len) begin
                     dist_ready = 1'b1;
                     du_st = 2;
                  end else if (spur && $urandom_range(0, 2) == 0) begin
                     dist_res_valid = 1'b1;
                     dist_res = '0;
                  end
               end
               2: begin
                  dist_ready = 1'b0;
                  chk("req_drop", dist_valid, 1'b0);
                  chk("req_hold", hold_err, 1'b0);
                  chk("dist_a", a0, cur_tp);
                  chk("dist_b", b0, mem[acc_cnt % NMAX]);
                  rv = dtab[acc_cnt % NMAX];
                  acc_cnt++;
                  lc = 1;
                  if (lc == l_len) begin
                     dist_res_valid = 1'b1; dist_res = rv; du_st = 0;
                  end else du_st = 3;
               end
               default: begin
                  lc++;
                  if (lc == l_len) begin
                     dist_res_valid = 1'b1; dist_res = rv; du_st = 0;
                  end
               end
            endcase
         end
      end
   end

   // Scoreboard: every done pulse consumes one expected search result.
   initial begin
      logic busy_prev;
      exp_t e;
      busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = expq.pop_front();
               chk("nb_cnt", nb_cnt, e.cnt);
               chk("nb_dist", nb_dist, e.d);
               chk("nb_idx", nb_idx, e.i);
               chk("busy_at_done", busy, 1'b0);
               chk("busy_before_done", busy_prev, 1'b1);
               chk("fetches", fetch_cnt, e.n);
               chk("accepts", acc_cnt, e.n);
               chk("addr_order", addr_err, 1'b0);
               if (e.n > 0) chk("last_addr", last_addr, e.n - 1);
               if (e.lat >= 0) chk("start_to_done", cyc - t0, e.lat);
            end
         end
         busy_prev = busy;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      int fc;
      for (int j = 0; j < NMAX; j++) mem[j] = $urandom;
      fill_dtab();
      repeat (3) @(negedge clk);
      chk_reset();
      rst = 1'b0;
      @(negedge clk);

      // Async reset while a request is pending; a stray result afterwards is ignored.
      du_en = 1'b0;
      fetch_cnt = 0; acc_cnt = 0; addr_err = 1'b0;
      @(negedge clk);
      start = 1'b1; n_points = 11'd3; test_point = $urandom;
      @(negedge clk);
      start = 1'b0;
      g = 0;
      while (!dist_valid && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("reach_issue", dist_valid, 1'b1);
      #2 rst = 1'b1;
      #1 chk_reset();
      @(negedge clk);
      rst = 1'b0;
      fc = fetch_cnt;
      inj_res = 1'b1;
      repeat (2) @(negedge clk);
      inj_res = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_cnt", nb_cnt, 0);
      chk("post_rst_dist", nb_dist, {K{DIST_MAX}});
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_fetch", fetch_cnt, fc);
      du_en = 1'b1;

      // Empty scan.
      run(0, 1'b0);

      // Directed ranking with ties.
      dtab[0] = 50; dtab[1] = 10; dtab[2] = 30; dtab[3] = 10; dtab[4] = 70; dtab[5] = 5;
      stall_cfg = 0; lat_cfg = 1;
      run(6, 1'b0);

      // Long ready stall, result latency 3, stray result strobes while stalled.
      fill_dtab();
      stall_cfg = 7; lat_cfg = 3; spur = 1'b1;
      run(5, 1'b0);

      // Partially filled list and start pulsed while busy.
      stall_cfg = 1; lat_cfg = 2; spur = 1'b0;
      run(2, 1'b1);
      run(1, 1'b0);

      // Randomised handshakes and sizes.
      rnd_mode = 1'b1; spur = 1'b1;
      for (int r = 0; r < 6; r++) begin
         fill_dtab();
         run(int'($urandom_range(1, 40)), 1'b0);
      end
      fill_dtab();
      run(K, 1'b0);

      // Full address space.
      rnd_mode = 1'b0; spur = 1'b0; stall_cfg = 0; lat_cfg = 1;
      fill_dtab();
      run(NMAX, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
